// File: rtl/lab3_dg_keypad_emu_if.sv
// Keypad emulator command/matrix bundle.
// master: command source plus scanner column drive; slave: the emulator.
interface lab3_dg_keypad_emu_if;
  logic [3:0] cols;
  logic [3:0] key;
  logic       start;
  logic [3:0] rows;
  logic       busy;
  logic       done;

  modport master (output cols, key, start, input rows, busy, done);
  modport slave  (input cols, key, start, output rows, busy, done);
endinterface

// File: rtl/lab3_dg_keypad_emu.sv
// Passive 4x4 keypad emulator: answers active-low column drive with
// active-low row levels for one commanded key, with optional contact bounce.
// Build option: define KEYPAD_EMU_BOUNCE_EN to include the bounce phases;
// without it a press is a clean HOLD followed by a clean GAP.
//
// state      | meaning
// IDLE       | open contact, waiting for start (also the default decode)
// BOUNCE_IN  | contact chatters while closing, closed first
// HOLD       | contact steadily closed
// BOUNCE_OUT | contact chatters while opening, open first
// GAP        | contact steadily open before a new command is accepted
module lab3_dg_keypad_emu #(
  parameter int BOUNCE_CYCLES = 240000,
  parameter int TOGGLE_CYCLES = 12000,
  parameter int HOLD_CYCLES   = 2400000,
  parameter int GAP_CYCLES    = 480000
) (
  input  logic                 int_osc,
  input  logic                 reset,
  lab3_dg_keypad_emu_if.slave  kp
);

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] phase_q, phase_d;
  logic        contact_q, contact_d;
  logic        done_q, done_d;
  logic [1:0]  krow_q, krow_d;
  logic [1:0]  kcol_q, kcol_d;
  logic [3:0]  rows_w;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [23:0] BOUNCE_LAST = 24'(BOUNCE_CYCLES - 1);
  localparam logic [23:0] TOGGLE_LAST = 24'(TOGGLE_CYCLES - 1);
  logic [23:0] tog_q, tog_d;
`else
  // Bounce timing is accepted for interface compatibility but has no effect.
  logic [47:0] unused_bounce_params;
  assign unused_bounce_params = {24'(BOUNCE_CYCLES), 24'(TOGGLE_CYCLES)};
`endif

  // State, counters, contact and latched key registers.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      krow_q    <= '0;
      kcol_q    <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      contact_q <= contact_d;
      done_q    <= done_d;
      krow_q    <= krow_d;
      kcol_q    <= kcol_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_q     <= tog_d;
`endif
    end
  end

  // Next-state, phase timing and contact behaviour; phase end beats a toggle.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 24'd1;
    contact_d = contact_q;
    done_d    = 1'b0;
    krow_d    = krow_q;
    kcol_d    = kcol_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    tog_d     = tog_q + 24'd1;
`endif
    case (state_q)
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_IN: begin
        if (phase_q == BOUNCE_LAST) begin
          state_d   = HOLD;
          contact_d = 1'b1;
          phase_d   = '0;
          tog_d     = '0;
        end else if (tog_q == TOGGLE_LAST) begin
          contact_d = ~contact_q;
          tog_d     = '0;
        end
      end
      BOUNCE_OUT: begin
        if (phase_q == BOUNCE_LAST) begin
          state_d   = GAP;
          contact_d = 1'b0;
          phase_d   = '0;
          tog_d     = '0;
        end else if (tog_q == TOGGLE_LAST) begin
          contact_d = ~contact_q;
          tog_d     = '0;
        end
      end
`endif
      HOLD: begin
        contact_d = 1'b1;
        if (phase_q == HOLD_LAST) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d = BOUNCE_OUT;
          tog_d   = '0;
`else
          state_d = GAP;
`endif
          contact_d = 1'b0;
          phase_d   = '0;
        end
      end
      GAP: begin
        contact_d = 1'b0;
        if (phase_q == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          phase_d = '0;
        end
      end
      default: begin
        contact_d = 1'b0;
        phase_d   = '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
        tog_d     = '0;
`endif
        if (kp.start) begin
          krow_d    = kp.key[3:2];
          kcol_d    = kp.key[1:0];
          contact_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d   = BOUNCE_IN;
`else
          state_d   = HOLD;
`endif
        end
      end
    endcase
  end

  // Zero-latency matrix: the latched row follows the latched column while closed.
  always_comb begin
    rows_w = 4'b1111;
    if (contact_q && !kp.cols[kcol_q]) rows_w[krow_q] = 1'b0;
  end

  assign kp.rows = rows_w;
  assign kp.busy = (state_q != IDLE);
  assign kp.done = done_q;

endmodule

// File: tb/tb_lab3_dg_keypad_emu.sv
module tb_lab3_dg_keypad_emu;
  localparam int B = 8;
  localparam int T = 2;
  localparam int H = 10;
  localparam int G = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int TOTAL    = 2 * B + H + G;
  localparam int HOLD_AT  = B;
`else
  localparam int TOTAL    = H + G;
  localparam int HOLD_AT  = 0;
`endif

  logic int_osc = 1'b0;
  logic reset   = 1'b1;

  lab3_dg_keypad_emu_if kp();

  lab3_dg_keypad_emu #(
    .BOUNCE_CYCLES(B), .TOGGLE_CYCLES(T), .HOLD_CYCLES(H), .GAP_CYCLES(G)
  ) dut (
    .int_osc(int_osc),
    .reset  (reset),
    .kp     (kp)
  );

  always #5 int_osc = ~int_osc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic [3:0] key;
    logic [3:0] cols;
    logic [3:0] rows;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge int_osc);
    #1;
  endtask

  // Contact level after edge k, k=0 being the edge that samples start.
  function automatic bit exp_contact(input int k);
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (k < B) return (T >= B) ? 1'b1 : ((k / T) % 2 == 0);
    if (k < B + H) return 1'b1;
    if (k < 2 * B + H) return (T >= B) ? 1'b0 : (((k - B - H) / T) % 2 == 1);
    return 1'b0;
`else
    return (k < H);
`endif
  endfunction

  function automatic logic [3:0] exp_rows(input logic [3:0] k, input logic [3:0] c, input bit closed);
    logic [3:0] r;
    r = 4'b1111;
    if (closed && !c[k[1:0]]) r[k[3:2]] = 1'b0;
    return r;
  endfunction

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!kp.done && n < 4 * TOTAL) begin
      step();
      n++;
    end
    check(tag, {5'd0, kp.done}, 6'd1);
    step();
  endtask

  // Full sequence against a queue of per-cycle expectations; optional
  // start with a different key injected while busy.
  task automatic run_trace(input logic [3:0] k, input logic [3:0] c, input int inject_at, input string tag);
    logic [5:0] e;
    kp.key   = k;
    kp.cols  = c;
    kp.start = 1'b1;
    for (int i = 0; i <= TOTAL + 1; i++)
      exp_q.push_back({exp_rows(k, c, exp_contact(i)), (i < TOTAL) ? 1'b1 : 1'b0, (i == TOTAL) ? 1'b1 : 1'b0});
    step();
    kp.start = 1'b0;
    for (int i = 0; i <= TOTAL + 1; i++) begin
      if (i > 0) step();
      if (i == inject_at) begin
        kp.start = 1'b1;
        kp.key   = 4'hF;
      end else if (i == inject_at + 1) begin
        kp.start = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 6'd1, 6'd0);
      end else begin
        e = exp_q.pop_front();
        check(tag, {kp.rows, kp.busy, kp.done}, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    kp.cols  = 4'b0000;
    kp.key   = 4'h0;
    kp.start = 1'b0;

    vecs[0] = '{key: 4'b0110, cols: 4'b1011, rows: 4'b1101};
    vecs[1] = '{key: 4'b0110, cols: 4'b1101, rows: 4'b1111};
    vecs[2] = '{key: 4'b0110, cols: 4'b0000, rows: 4'b1101};
    vecs[3] = '{key: 4'hF,    cols: 4'b0111, rows: 4'b0111};
    vecs[4] = '{key: 4'hF,    cols: 4'b1111, rows: 4'b1111};
    vecs[5] = '{key: 4'h0,    cols: 4'b1110, rows: 4'b1110};
    vecs[6] = '{key: 4'h0,    cols: 4'b0001, rows: 4'b1111};
    vecs[7] = '{key: 4'b1001, cols: 4'b1101, rows: 4'b1011};

    #12;
    check("reset_state", {kp.rows, kp.busy, kp.done}, {4'b1111, 1'b0, 1'b0});
    @(negedge int_osc);
    reset = 1'b0;
    step();

    // Static matrix during HOLD.
    for (int v = 0; v < 8; v++) begin
      kp.cols  = 4'b1111;
      kp.key   = vecs[v].key;
      kp.start = 1'b1;
      step();
      kp.start = 1'b0;
      repeat (HOLD_AT + 2) step();
      kp.cols = vecs[v].cols;
      #1;
      check($sformatf("static_rows_%0d", v), {kp.rows, 2'b00}, {vecs[v].rows, 2'b00});
      kp.cols = 4'b1111;
      wait_done($sformatf("static_done_%0d", v));
    end

    // Bounce shape, done timing.
    run_trace(4'b0110, 4'b0000, -1, "shape");
    run_trace(4'hA, 4'b0000, -1, "shape_keyA");

    // start with key F while busy is ignored.
    run_trace(4'h0, 4'b0000, 5, "busy_ignore");

    // start held through done restarts at once.
    kp.key   = 4'b0101;
    kp.cols  = 4'b0000;
    kp.start = 1'b1;
    step();
    repeat (TOTAL) step();
    check("held_start_done", {kp.rows, kp.busy, kp.done}, {4'b1111, 1'b0, 1'b1});
    step();
    check("held_start_restart", {kp.rows, kp.busy, kp.done}, {4'b1101, 1'b1, 1'b0});
    kp.start = 1'b0;
    wait_done("held_start_second_done");

    // Asynchronous reset in HOLD.
    kp.key   = 4'h0;
    kp.cols  = 4'b0000;
    kp.start = 1'b1;
    step();
    kp.start = 1'b0;
    repeat (HOLD_AT + 3) step();
    check("pre_reset_rows", {kp.rows, kp.busy, kp.done}, {4'b1110, 1'b1, 1'b0});
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", {kp.rows, kp.busy, kp.done}, {4'b1111, 1'b0, 1'b0});
    @(negedge int_osc);
    reset = 1'b0;
    step();
    run_trace(4'h0, 4'b0000, -1, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lab3_dg_keypad_emu.md
# lab3_dg_keypad_emu

Keypad matrix emulator: the passive 4x4 keypad at the far end of the column-drive / row-sense interface. It answers the scanner's active-low column drive with active-low row levels for one commanded key, including mechanical contact bounce on press and release. It is used for on-board self-test and closed-loop simulation of the scanner and debouncer. The emulator sits between a command source (switches or test sequencer) and the scanner's `cols` outputs and `sync` row inputs.

## Interface
- `BOUNCE_CYCLES`, default 240000: length of each bounce phase in clocks (5 ms at 48 MHz).
- `TOGGLE_CYCLES`, default 12000: contact toggle interval during bounce.
- `HOLD_CYCLES`, default 2400000: steady-closed time in clocks (50 ms).
- `GAP_CYCLES`, default 480000: steady-open time after release, before the emulator accepts a new command.
- Every parameter is in the range 1 to 2^24-1.
- `int_osc` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `cols` input 4: column drive from the scanner, active-low. Any number of bits may be low.
- `key` input 4: key to press. Row index is `key[3:2]`; column index is `key[1:0]`.
- `start` input 1: press request, sampled in IDLE.
- `rows` output 4: row levels to the scanner, active-low. Reset value 4'b1111.
- `busy` output 1: high in every state except IDLE. Reset value 0.
- `done` output 1: one-cycle pulse when a press/release sequence completes. Reset value 0.

## Operation
- Registered state machine with states IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- It uses a 24-bit phase counter, a 24-bit toggle counter, a `contact` flop, and latched `krow`/`kcol`.
- Row output is combinational from `cols`, which gives zero-latency matrix behaviour:
  - `rows[krow]` = 0 when `contact` = 1 and `cols[kcol]` = 0.
  - All other `rows` bits are 1.
- IDLE: `contact` = 0.
  - On `start` = 1, latch `key` into `krow`/`kcol`, set `contact` = 1, clear both counters, and go to BOUNCE_IN.
- BOUNCE_IN:
  - The toggle counter counts up. When it reaches TOGGLE_CYCLES-1, `contact` inverts and the toggle counter clears.
  - When the phase counter reaches BOUNCE_CYCLES-1, go to HOLD with `contact` forced to 1 and counters cleared.
- HOLD: `contact` stays 1.
  - At phase count HOLD_CYCLES-1, go to BOUNCE_OUT with `contact` = 0 and counters cleared.
- BOUNCE_OUT: toggles exactly as in BOUNCE_IN, starting from open.
  - At phase count BOUNCE_CYCLES-1, go to GAP with `contact` forced to 0.
- GAP: `contact` stays 0.
  - At phase count GAP_CYCLES-1, go to IDLE and register `done` = 1 for that first IDLE cycle.
- Boundary rules:
  - `start` while busy is ignored, and `key` changes while busy are ignored (latched values are used).
  - `start` in the same cycle that `done` is high is accepted.
  - If TOGGLE_CYCLES ≥ BOUNCE_CYCLES, no toggle occurs and the bounce phase is a clean edge.
  - Reset mid-sequence: state goes to IDLE, `contact` = 0, counters = 0, `done` = 0. `rows` = 4'b1111 asynchronously, with no glitch to 0.
  - The `default` state decodes as IDLE.

## Timing
- Say `start` is sampled at edge 0. Then:
  - `contact` = 1 from edge 0.
  - The first toggle happens at edge TOGGLE_CYCLES.
  - HOLD is entered at edge BOUNCE_CYCLES.
  - BOUNCE_OUT is entered at edge BOUNCE_CYCLES+HOLD_CYCLES.
  - GAP is entered at edge 2*BOUNCE_CYCLES+HOLD_CYCLES.
  - `done` is high for one cycle after edge 2*BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES.
- `busy` rises at edge 0 and falls with `done`.
- `cols` to `rows` is a combinational path with no clock latency.

## Configuration
- `KEYPAD_EMU_BOUNCE_EN` defined: full sequence as above.
- `KEYPAD_EMU_BOUNCE_EN` undefined: BOUNCE_IN and BOUNCE_OUT are not built.
  - IDLE goes to HOLD, and HOLD goes to GAP. Transitions are clean.
  - Total sequence is HOLD_CYCLES+GAP_CYCLES clocks.
  - The toggle counter is removed.
  - Parameter BOUNCE_CYCLES is accepted but unused.

## Test plan
All scenarios use BOUNCE_CYCLES=8, TOGGLE_CYCLES=2, HOLD_CYCLES=10, GAP_CYCLES=4, with the bounce macro defined unless stated.

- Static matrix: `key`=4'b0110 pressed, `cols`=4'b1011, sampled during HOLD.
  - Required: `rows`=4'b1101.
  - With `cols`=4'b1101: `rows`=4'b1111.
  - With `cols`=4'b0000: `rows`=4'b1101.
- Bounce shape, with `cols`=4'b0000:
  - `rows[krow]` toggles every 2 cycles during edges 0–7 (closed first), then stays low for 10 cycles.
  - It then toggles for 8 cycles (open first), then stays 1.
  - `done` pulses exactly 30 cycles after `start`.
- Busy rule: `start` with `key`=4'hF at cycle 5 of a `key`=4'h0 sequence.
  - Required: ignored. Only row 0 / column 0 responds.
  - `start` held high through the `done` cycle immediately starts a new sequence.
- Reset mid-HOLD: assert `reset` asynchronously, between edges.
  - Required: `rows`=4'b1111, `busy`=0, `done`=0 immediately.
  - After release, a new `start` gives the full 30-cycle sequence.
- Scanner loopback: emulator connected to the scanner with full-size parameters.
  - Required: each of the 16 keys gives exactly one scanner `alarm` pulse.
  - Its `keypress` has the low column bit at `kcol` and the low row bit at `krow`.
- Macro undefined: same stimulus as the bounce-shape scenario.
  - Required: no toggles, row low for exactly 10 cycles, `done` at cycle 14.
